// File: rtl/bbqm_teller_ctrl.sv
// Teller controller: call arbiter plus three teller service FSMs.
// Optional served counter enabled by defining BBQM_SERVED_CNT_EN.
module bbqm_teller_ctrl #(
    parameter int SERVICE_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] pcount,
    input  logic [1:0] tcount,
    input  logic       dec_ack,
    output logic       dec_req,
    output logic [1:0] call_id,
    output logic [2:0] teller_busy,
    output logic [7:0] served
);

    typedef enum logic {A_IDLE, A_REQ} arb_t;
    typedef enum logic {IDLE, SERVE} tel_t;

    localparam logic [3:0] LAST = 4'(SERVICE_TICKS - 1);

    arb_t       a_state, a_next;
    logic [1:0] id_q, id_d;
    tel_t       t_state [3];
    tel_t       t_next  [3];
    logic [3:0] timer   [3];
    logic [3:0] timer_d [3];
    logic [2:0] active;
    logic [2:0] elig;
    logic       take;

    assign active = {tcount > 2'd2, tcount > 2'd1, tcount != 2'd0};
    assign take   = (a_state == A_REQ) && dec_ack;

    always_comb begin
        elig = '0;
        for (int i = 0; i < 3; i++)
            elig[i] = active[i] && (t_state[i] == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_state <= A_IDLE;
            id_q    <= '0;
        end else begin
            a_state <= a_next;
            id_q    <= id_d;
        end
    end

    always_comb begin
        a_next = a_state;
        id_d   = id_q;
        unique case (a_state)
            A_IDLE: begin
                if (pcount != 4'd0 && elig != 3'b000) begin
                    a_next = A_REQ;
                    if (elig[0])      id_d = 2'd0;
                    else if (elig[1]) id_d = 2'd1;
                    else              id_d = 2'd2;
                end
            end
            A_REQ: begin
                // ack takes priority over withdrawal; both leave A_REQ
                if (dec_ack || pcount == 4'd0)
                    a_next = A_IDLE;
            end
            default: a_next = A_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                t_state[i] <= IDLE;
                timer[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                t_state[i] <= t_next[i];
                timer[i]   <= timer_d[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            t_next[i]  = t_state[i];
            timer_d[i] = timer[i];
            unique case (t_state[i])
                IDLE: begin
                    if (take && id_q == 2'(i)) begin
                        t_next[i]  = SERVE;
                        timer_d[i] = '0;
                    end
                end
                SERVE: begin
                    if (tick) begin
                        if (timer[i] == LAST) begin
                            t_next[i]  = IDLE;
                            timer_d[i] = '0;
                        end else begin
                            timer_d[i] = timer[i] + 4'd1;
                        end
                    end
                end
                default: t_next[i] = IDLE;
            endcase
        end
    end

    assign dec_req = (a_state == A_REQ);
    assign call_id = id_q;

    always_comb begin
        teller_busy = '0;
        for (int i = 0; i < 3; i++)
            teller_busy[i] = (t_state[i] == SERVE);
    end

`ifdef BBQM_SERVED_CNT_EN
    logic [7:0] served_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            served_q <= '0;
        else if (take && served_q != 8'hFF)
            served_q <= served_q + 8'd1;
    end

    assign served = served_q;
`else
    assign served = '0;
`endif

endmodule

// File: tb/tb_bbqm_teller_ctrl.sv
// Scoreboard bench for bbqm_teller_ctrl against a remaining-ticks model.
// Honours BBQM_SERVED_CNT_EN for the served expectation.
module tb_bbqm_teller_ctrl;

    localparam int ST = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       tick;
    logic [3:0] pcount;
    logic [1:0] tcount;
    logic       dec_ack;
    logic       dec_req;
    logic [1:0] call_id;
    logic [2:0] teller_busy;
    logic [7:0] served;

    bbqm_teller_ctrl #(.SERVICE_TICKS(ST)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .pcount(pcount),
        .tcount(tcount),
        .dec_ack(dec_ack),
        .dec_req(dec_req),
        .call_id(call_id),
        .teller_busy(teller_busy),
        .served(served)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       dr;
        logic [1:0] id;
        logic [2:0] busy;
        logic [7:0] srv;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    // reference: a pending call flag and remaining service ticks per teller
    bit m_req;
    int m_id;
    int m_rem[3];
    int m_srv;

    task automatic model_reset();
        m_req = 0;
        m_id  = 0;
        m_srv = 0;
        for (int i = 0; i < 3; i++) m_rem[i] = 0;
    endtask

    task automatic model_edge();
        int  nrem[3];
        bit  nreq;
        int  nid;
        bit  found;
        nreq  = m_req;
        nid   = m_id;
        found = 0;
        for (int i = 0; i < 3; i++)
            nrem[i] = (m_rem[i] > 0 && tick) ? m_rem[i] - 1 : m_rem[i];
        if (m_req) begin
            if (dec_ack) begin
                nrem[m_id] = ST;
                if (m_srv < 255) m_srv++;
                nreq = 0;
            end else if (pcount == 0) begin
                nreq = 0;
            end
        end else if (pcount != 0) begin
            for (int i = 0; i < 3; i++)
                if (!found && i < int'(tcount) && m_rem[i] == 0) begin
                    found = 1;
                    nid   = i;
                end
            if (found) nreq = 1;
        end
        m_req = nreq;
        m_id  = nid;
        for (int i = 0; i < 3; i++) m_rem[i] = nrem[i];
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.dr = m_req;
        e.id = 2'(m_id);
        for (int i = 0; i < 3; i++) e.busy[i] = (m_rem[i] > 0);
`ifdef BBQM_SERVED_CNT_EN
        e.srv = 8'(m_srv);
`else
        e.srv = 8'd0;
`endif
        return e;
    endfunction

    task automatic step(input logic t, input logic [3:0] p,
                        input logic [1:0] tc, input logic a);
        @(negedge clk);
        tick    = t;
        pcount  = p;
        tcount  = tc;
        dec_ack = a;
        model_edge();
        sbq.push_back(model_out());
    endtask

    initial begin : monitor
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                g = {dec_req, call_id, teller_busy, served};
                checks++;
                if (g !== e) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t got req=%b id=%0d busy=%b srv=%0d exp req=%b id=%0d busy=%b srv=%0d",
                             $time, g.dr, g.id, g.busy, g.srv,
                             e.dr, e.id, e.busy, e.srv);
                end
            end
        end
    end

    task automatic check_zero(input string name);
        checks++;
        if ({dec_req, call_id, teller_busy, served} !== 14'd0) begin
            errors++;
            $display("FAIL %s got req=%b id=%0d busy=%b srv=%0d exp all 0",
                     name, dec_req, call_id, teller_busy, served);
        end
    endtask

    task automatic do_reset(input string name);
        @(negedge clk);
        #2 reset = 1'b1;
        #1 check_zero(name);
        model_reset();
        @(negedge clk);
        reset   = 1'b0;
        tick    = 1'b0;
        pcount  = 4'd0;
        dec_ack = 1'b0;
        model_edge();
        sbq.push_back(model_out());
    endtask

    initial begin : stim
        int  pc;
        bit  a;
        bit  r;
        logic [1:0] tc;
        reset   = 1'b1;
        tick    = 1'b0;
        pcount  = 4'd0;
        tcount  = 2'd0;
        dec_ack = 1'b0;
        model_reset();
        #1 check_zero("reset_init");
        @(negedge clk);
        reset = 1'b0;
        model_edge();
        sbq.push_back(model_out());

        // two customers, one teller, ack one cycle after each request
        pc = 2;
        for (int c = 0; c < 40; c++) begin
            r = m_req;
            step(c % 4 == 3, 4'(pc), 2'd1, r);
            if (r && pc > 0) pc--;
        end

        // five customers, three tellers, no ticks: three calls then stall
        pc = 5;
        for (int c = 0; c < 20; c++) begin
            r = m_req;
            step(1'b0, 4'(pc), 2'd3, r);
            if (r && pc > 0) pc--;
        end
        for (int c = 0; c < 24; c++) begin
            r = m_req;
            step(c % 2 == 1, 4'(pc), 2'd3, r);
            if (r && pc > 0) pc--;
        end

        // withdrawal while a request is pending
        do_reset("reset_between");
        step(1'b0, 4'd3, 2'd2, 1'b0);
        step(1'b0, 4'd3, 2'd2, 1'b0);
        step(1'b0, 4'd0, 2'd2, 1'b0);
        step(1'b0, 4'd0, 2'd2, 1'b1);
        step(1'b0, 4'd0, 2'd2, 1'b0);

        // teller 2 busy when tcount drops to 1
        pc = 7;
        for (int c = 0; c < 14; c++) begin
            r = m_req;
            step(1'b0, 4'(pc), 2'd3, r);
            if (r && pc > 0) pc--;
        end
        pc = 7;
        for (int c = 0; c < 40; c++) begin
            r = m_req;
            step(c % 3 == 0, 4'(pc), 2'd1, r);
            if (r && pc > 1) pc--;
        end

        // saturate the served counter
        for (int c = 0; c < 700; c++) begin
            r = m_req;
            step(1'b1, 4'd7, 2'd3, r);
        end

        // randomized traffic, including acks while idle
        pc = 4;
        tc = 2'd3;
        for (int c = 0; c < 2500; c++) begin
            r = m_req;
            if ($urandom_range(0, 19) == 0) pc = $urandom_range(0, 7);
            if ($urandom_range(0, 39) == 0) tc = 2'($urandom_range(0, 3));
            a = r ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) == 0);
            step($urandom_range(0, 3) == 0, 4'(pc), tc, a);
            if (r && a && pc > 0) pc--;
            if (pc == 0 && $urandom_range(0, 4) == 0) pc = $urandom_range(1, 7);
        end

        // reset with a request pending and tellers 0,1 busy
        do_reset("reset_pre");
        for (int c = 0; c < 20; c++) begin
            r = m_req && !(m_rem[0] > 0 && m_rem[1] > 0);
            step(1'b0, 4'd7, 2'd3, r);
        end
        do_reset("reset_mid");
        for (int c = 0; c < 6; c++) step(1'b0, 4'd0, 2'd3, 1'b0);
        for (int c = 0; c < 10; c++) begin
            r = m_req;
            step(1'b1, 4'd2, 2'd3, r);
        end

        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", sbq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
